// File: rtl/cr_core_pkg.sv
// Shared definitions for the CR-CPU core: opcodes, jump conditions and FSM states.
package cr_core_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_SHIFT = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd5;
    localparam logic [3:0] OP_STORE = 4'd6;
    localparam logic [3:0] OP_MOVE  = 4'd7;
    localparam logic [3:0] OP_JUMP  = 4'd8;
    localparam logic [3:0] OP_LOADC = 4'd9;
    localparam logic [3:0] OP_JCOND = 4'd10;
    localparam logic [3:0] OP_OUT   = 4'd11;
    localparam logic [3:0] OP_HALT  = 4'd12;
    localparam logic [3:0] OP_NOP13 = 4'd13;
    localparam logic [3:0] OP_NOP14 = 4'd14;
    localparam logic [3:0] OP_NOP15 = 4'd15;

    localparam logic [1:0] COND_Z  = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_C  = 2'b10;
    localparam logic [1:0] COND_NC = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXECUTE,
        ST_WAIT_LOAD,
        ST_HALTED
    } state_t;

    function automatic logic cond_met(input logic [1:0] cond, input logic z, input logic c);
        case (cond)
            COND_Z:  return z;
            COND_NZ: return !z;
            COND_C:  return c;
            default: return !c;
        endcase
    endfunction

endpackage

// File: rtl/cr_core_alu.sv
// Combinational ALU for ops 0-4: add/sub/and/or and logical shifts, with zero and carry flags.
module cr_core_alu
    import cr_core_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  shift_right,
    input  logic [7:0]            shift_amt,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  carry
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_SHIFT: begin
                // Shifting by the full width or more clears the value.
                if (int'(shift_amt) >= DATA_WIDTH)
                    result = '0;
                else if (shift_right)
                    result = a >> shift_amt;
                else
                    result = a << shift_amt;
            end
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/cr_core.sv
// CR-CPU execution core: fetch/execute FSM, four-entry register file, flags and memory ports.
module cr_core
    import cr_core_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int IADDR_WIDTH = 8,
    parameter int DADDR_WIDTH = 8,
    parameter int OUT_WIDTH   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_run,
    output logic [IADDR_WIDTH-1:0] o_iaddr,
    input  logic [15:0]            i_inst,
    output logic [DADDR_WIDTH-1:0] o_daddr,
    output logic                   o_dwe,
    output logic [DATA_WIDTH-1:0]  o_dwdata,
    input  logic [DATA_WIDTH-1:0]  i_drdata,
    output logic [OUT_WIDTH-1:0]   o_out,
    output logic                   o_halted
);

    state_t                 state;
    logic [IADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]  regs [4];
    logic                   flag_z;
    logic                   flag_c;
    logic [OUT_WIDTH-1:0]   out_reg;
    logic [1:0]             ld_dst;

    logic [3:0]             op;
    logic [1:0]             hi;
    logic [1:0]             lo;
    logic [7:0]             k;
    logic [DATA_WIDTH-1:0]  k_ext;
    logic [DATA_WIDTH-1:0]  alu_a;
    logic [DATA_WIDTH-1:0]  alu_b;
    logic [DATA_WIDTH-1:0]  alu_result;
    logic                   alu_z;
    logic                   alu_c;
    logic [IADDR_WIDTH-1:0] pc_inc;
    logic [IADDR_WIDTH-1:0] jump_target;
    logic [IADDR_WIDTH-1:0] jcond_target;

    assign op    = i_inst[15:12];
    assign hi    = i_inst[11:10];
    assign lo    = i_inst[9:8];
    assign k     = i_inst[7:0];
    assign k_ext = {{(DATA_WIDTH-8){1'b0}}, k};

    // SHIFT operates on its own destination; the other ALU ops pick a from r0/r1.
    assign alu_a = (op == OP_SHIFT) ? regs[hi] : (lo[1] ? regs[1] : regs[0]);
    assign alu_b = lo[0] ? k_ext : regs[2];

    cr_core_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op          (op),
        .a           (alu_a),
        .b           (alu_b),
        .shift_right (lo[0]),
        .shift_amt   (lo[1] ? k : regs[3][7:0]),
        .result      (alu_result),
        .zero        (alu_z),
        .carry       (alu_c)
    );

    assign pc_inc       = pc + IADDR_WIDTH'(1);
    assign jump_target  = lo[0] ? k_ext[IADDR_WIDTH-1:0] : regs[hi][IADDR_WIDTH-1:0];
    assign jcond_target = lo[0] ? k_ext[IADDR_WIDTH-1:0] : regs[0][IADDR_WIDTH-1:0];

    // Effective address computed at address width, which wraps the same as truncating afterwards.
    assign o_daddr  = (lo == 2'd0) ? k_ext[DADDR_WIDTH-1:0]
                                   : regs[lo][DADDR_WIDTH-1:0] + k_ext[DADDR_WIDTH-1:0];
    assign o_dwdata = regs[hi];
    assign o_dwe    = (state == ST_EXECUTE) && (op == OP_STORE);
    assign o_iaddr  = pc;
    assign o_out    = out_reg;
    assign o_halted = (state == ST_HALTED);

    // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_FETCH;
            pc      <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            out_reg <= '0;
            ld_dst  <= 2'd0;
            // NOTE: the register file is architectural state that must read zero after
            // reset, so unlike a RAM it is reset like any other flop.
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (i_run) state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    pc    <= pc_inc;
                    state <= ST_FETCH;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHIFT: begin
                            regs[hi] <= alu_result;
                            flag_z   <= alu_z;
                            flag_c   <= alu_c;
                        end
                        OP_LOAD: begin
                            // PC advances when the data returns.
                            pc     <= pc;
                            ld_dst <= hi;
                            state  <= ST_WAIT_LOAD;
                        end
                        OP_MOVE:  regs[hi] <= regs[lo];
                        OP_JUMP:  pc <= jump_target;
                        OP_LOADC: begin
                            if (lo[0]) regs[hi][15:8] <= k;
                            else       regs[hi]       <= k_ext;
                        end
                        OP_JCOND: begin
                            if (cond_met(hi, flag_z, flag_c)) pc <= jcond_target;
                        end
                        OP_OUT:  out_reg <= regs[hi][OUT_WIDTH-1:0];
                        OP_HALT: state <= ST_HALTED;
                        default: ;
                    endcase
                end
                ST_WAIT_LOAD: begin
                    regs[ld_dst] <= i_drdata;
                    pc           <= pc_inc;
                    state        <= ST_FETCH;
                end
                default: state <= ST_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_core.sv
// Directed program-level test of cr_core with a ROM/RAM model and a store scoreboard.
module tb_cr_core;
    import cr_core_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } store_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [7:0]  iaddr;
    logic [15:0] inst;
    logic [7:0]  daddr;
    logic        dwe;
    logic [15:0] dwdata;
    logic [15:0] drdata;
    logic [2:0]  out;
    logic        halted;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    store_t      sb [$];
    int          total = 0;
    int          bad   = 0;

    cr_core #(
        .DATA_WIDTH  (16),
        .IADDR_WIDTH (8),
        .DADDR_WIDTH (8),
        .OUT_WIDTH   (3)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_run    (run),
        .o_iaddr  (iaddr),
        .i_inst   (inst),
        .o_daddr  (daddr),
        .o_dwe    (dwe),
        .o_dwdata (dwdata),
        .i_drdata (drdata),
        .o_out    (out),
        .o_halted (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM and data RAM: read data is valid one cycle after the address.
    always @(posedge clk) begin
        inst <= imem[iaddr];
        if (dwe) dmem[daddr] <= dwdata;
        drdata <= dmem[daddr];
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] hi,
                                        input logic [1:0] lo, input logic [7:0] k);
        return {op, hi, lo, k};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) imem[i] = enc(OP_NOP13, 2'd0, 2'd0, 8'h00);
    endtask

    // One cycle, sampled on the falling edge; any write strobe is matched against the scoreboard.
    task automatic tick();
        store_t e;
        @(negedge clk);
        if (dwe === 1'b1) begin
            check("store_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("store_addr", 32'(daddr), 32'(e.addr));
                check("store_data", 32'(dwdata), 32'(e.data));
            end
        end
    endtask

    task automatic run_instr(input int n, input logic [7:0] exp_pc, input string tag);
        repeat (n) tick();
        check(tag, 32'(iaddr), 32'(exp_pc));
    endtask

    initial begin
        rst_n = 1'b1;
        run   = 1'b0;
        clear_rom();
        imem[8'h00] = enc(OP_LOADC, 2'd0, 2'd0, 8'h34);
        imem[8'h01] = enc(OP_LOADC, 2'd0, 2'd1, 8'h12);
        imem[8'h02] = enc(OP_OUT,   2'd0, 2'd0, 8'h00);
        imem[8'h03] = enc(OP_STORE, 2'd0, 2'd0, 8'h40);
        imem[8'h04] = enc(OP_LOADC, 2'd0, 2'd0, 8'hFF);
        imem[8'h05] = enc(OP_LOADC, 2'd0, 2'd1, 8'hFF);
        imem[8'h06] = enc(OP_LOADC, 2'd2, 2'd0, 8'h01);
        imem[8'h07] = enc(OP_ADD,   2'd1, 2'd0, 8'h00);
        imem[8'h08] = enc(OP_STORE, 2'd1, 2'd0, 8'h41);
        imem[8'h09] = enc(OP_JCOND, COND_NC, 2'd1, 8'h30);
        imem[8'h0A] = enc(OP_JCOND, COND_Z,  2'd1, 8'h20);
        imem[8'h20] = enc(OP_JCOND, COND_NZ, 2'd1, 8'h30);
        imem[8'h21] = enc(OP_LOADC, 2'd1, 2'd0, 8'h10);
        imem[8'h22] = enc(OP_LOADC, 2'd3, 2'd0, 8'hAB);
        imem[8'h23] = enc(OP_STORE, 2'd3, 2'd1, 8'h05);
        imem[8'h24] = enc(OP_LOAD,  2'd2, 2'd1, 8'h05);
        imem[8'h25] = enc(OP_STORE, 2'd2, 2'd0, 8'h42);
        imem[8'h26] = enc(OP_SHIFT, 2'd3, 2'd2, 8'd20);
        imem[8'h27] = enc(OP_JCOND, COND_Z, 2'd1, 8'h30);
        imem[8'h30] = enc(OP_STORE, 2'd3, 2'd0, 8'h43);
        imem[8'h31] = enc(OP_LOADC, 2'd0, 2'd0, 8'h00);
        imem[8'h32] = enc(OP_LOADC, 2'd0, 2'd1, 8'h80);
        imem[8'h33] = enc(OP_SHIFT, 2'd0, 2'd3, 8'd1);
        imem[8'h34] = enc(OP_STORE, 2'd0, 2'd0, 8'h44);
        imem[8'h35] = enc(OP_SUB,   2'd1, 2'd3, 8'h20);
        imem[8'h36] = enc(OP_JCOND, COND_C, 2'd1, 8'h38);
        imem[8'h38] = enc(OP_STORE, 2'd1, 2'd0, 8'h45);
        imem[8'h39] = enc(OP_AND,   2'd2, 2'd1, 8'hFF);
        imem[8'h3A] = enc(OP_OR,    2'd3, 2'd2, 8'h00);
        imem[8'h3B] = enc(OP_MOVE,  2'd0, 2'd3, 8'h00);
        imem[8'h3C] = enc(OP_STORE, 2'd0, 2'd2, 8'h46);
        imem[8'h3D] = enc(OP_JCOND, COND_NC, 2'd0, 8'h00);
        imem[8'hF0] = enc(OP_LOADC, 2'd1, 2'd0, 8'hFF);
        imem[8'hF1] = enc(OP_JUMP,  2'd1, 2'd0, 8'h00);

        #2 rst_n = 1'b0;
        tick();
        check("rst_iaddr",  32'(iaddr),  32'h0);
        check("rst_out",    32'(out),    32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_dwe",    32'(dwe),    32'h0);
        rst_n = 1'b1;
        run   = 1'b1;

        // Constant loads and output register.
        run_instr(2, 8'h01, "loadc_lo_pc");
        run_instr(2, 8'h02, "loadc_hi_pc");
        run_instr(2, 8'h03, "out_pc");
        check("out_value", 32'(out), 32'h4);
        sb.push_back('{8'h40, 16'h1234});
        run_instr(2, 8'h04, "store_r0_pc");

        // 0xFFFF + 1 gives zero with carry.
        run_instr(2, 8'h05, "pc_05");
        run_instr(2, 8'h06, "pc_06");
        run_instr(2, 8'h07, "pc_07");
        run_instr(2, 8'h08, "add_pc");
        sb.push_back('{8'h41, 16'h0000});
        run_instr(2, 8'h09, "store_r1_pc");
        run_instr(2, 8'h0A, "jcond_nc_not_taken");
        run_instr(2, 8'h20, "jcond_z_taken");
        run_instr(2, 8'h21, "jcond_nz_not_taken");

        // Base+offset store, then load back from the same address.
        run_instr(2, 8'h22, "pc_22");
        run_instr(2, 8'h23, "pc_23");
        sb.push_back('{8'h15, 16'h00AB});
        run_instr(2, 8'h24, "store_based_pc");
        run_instr(3, 8'h25, "load_three_cycles");
        sb.push_back('{8'h42, 16'h00AB});
        run_instr(2, 8'h26, "store_loaded_pc");

        // Oversized left shift clears the register and sets Z.
        run_instr(2, 8'h27, "shift_big_pc");
        run_instr(2, 8'h30, "jcond_z_after_shift");
        sb.push_back('{8'h43, 16'h0000});
        run_instr(2, 8'h31, "store_shift_zero_pc");
        run_instr(2, 8'h32, "pc_32");
        run_instr(2, 8'h33, "pc_33");
        run_instr(2, 8'h34, "shift_right_pc");
        sb.push_back('{8'h44, 16'h4000});
        run_instr(2, 8'h35, "store_shift_right_pc");

        // Borrowing subtract, logic ops, MOVE keeps flags, register-target JCOND.
        run_instr(2, 8'h36, "sub_pc");
        run_instr(2, 8'h38, "jcond_c_after_borrow");
        sb.push_back('{8'h45, 16'hFFF0});
        run_instr(2, 8'h39, "store_sub_pc");
        run_instr(2, 8'h3A, "and_pc");
        run_instr(2, 8'h3B, "or_pc");
        run_instr(2, 8'h3C, "move_pc");
        sb.push_back('{8'h46, 16'hFFF0});
        run_instr(2, 8'h3D, "store_move_pc");
        run_instr(2, 8'hF0, "jcond_nc_reg_target");
        run_instr(2, 8'hF1, "pc_f1");
        run_instr(2, 8'hFF, "jump_reg_target");

        // NOP at 0xFF wraps the PC; dropping run mid-instruction lets it finish, then holds.
        tick();
        run = 1'b0;
        tick();
        check("pc_wrap", 32'(iaddr), 32'h00);
        repeat (4) tick();
        check("run_hold", 32'(iaddr), 32'h00);
        check("sb_drained_1", 32'(sb.size()), 32'd0);

        // Reset while a load is outstanding.
        rst_n = 1'b0;
        clear_rom();
        imem[8'h00] = enc(OP_LOADC, 2'd1, 2'd0, 8'h77);
        imem[8'h01] = enc(OP_STORE, 2'd1, 2'd0, 8'h20);
        imem[8'h02] = enc(OP_OUT,   2'd1, 2'd0, 8'h00);
        imem[8'h03] = enc(OP_LOAD,  2'd3, 2'd0, 8'h20);
        tick();
        rst_n = 1'b1;
        run   = 1'b1;
        run_instr(2, 8'h01, "p2_loadc_pc");
        sb.push_back('{8'h20, 16'h0077});
        run_instr(2, 8'h02, "p2_store_pc");
        run_instr(2, 8'h03, "p2_out_pc");
        check("p2_out_value", 32'(out), 32'h7);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("wl_rst_iaddr",  32'(iaddr),  32'h0);
        check("wl_rst_out",    32'(out),    32'h0);
        check("wl_rst_halted", 32'(halted), 32'h0);
        check("wl_rst_dwe",    32'(dwe),    32'h0);

        // Registers must read zero after that reset; HALT then freezes the core.
        clear_rom();
        imem[8'h00] = enc(OP_STORE, 2'd3, 2'd0, 8'h30);
        imem[8'h01] = enc(OP_STORE, 2'd1, 2'd0, 8'h31);
        imem[8'h02] = enc(OP_HALT,  2'd0, 2'd0, 8'h00);
        imem[8'h03] = enc(OP_STORE, 2'd0, 2'd0, 8'h50);
        tick();
        rst_n = 1'b1;
        sb.push_back('{8'h30, 16'h0000});
        run_instr(2, 8'h01, "p3_store_r3_pc");
        sb.push_back('{8'h31, 16'h0000});
        run_instr(2, 8'h02, "p3_store_r1_pc");
        run_instr(2, 8'h03, "halt_pc");
        check("halted_set", 32'(halted), 32'h1);
        repeat (6) tick();
        check("halt_pc_frozen", 32'(iaddr), 32'h03);
        check("halt_stays", 32'(halted), 32'h1);
        check("sb_drained_2", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
